ras_restorable: RTL and testbench
=================================

// Module: ras_restorable
// PURPOSE
//   Parametrised return address stack for the fetch predictor, used for BTB RET/RET_L/JUMP_L/INDIRECT_L actions.
//   Circular buffer with a wrapping top index and a saturating occupancy count.
//   Each access reports a {index, count} checkpoint. A backend mispredict update restores that checkpoint in one cycle.
//   Sits beside the BTB/UPCT/IBTB in the fetch predictor stage. Unlike the fixed 16-entry stack, it adds a
//   restorable checkpoint, simultaneous pop+push (coroutine) replace, and an underflow flag.
// PARAMETERS
//   RAS_ENTRIES   16      stack depth; power of 2, >= 2
//   PC_WIDTH      38      width of stored return PC (PC38)
//   INIT_PC       '0      reset value of every stack entry
//   (local) LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES); IDX_W = LOG_RAS_ENTRIES; CNT_W = LOG_RAS_ENTRIES+1
// PORTS
//   CLK                 in   1         clock, all state updates on posedge
//   nRST                in   1         asynchronous active-low reset
//   link_valid          in   1         push link_pc (call: JAL/JALR with rd=ra/t0)
//   link_pc             in   PC_WIDTH  return PC to push
//   ret_valid           in   1         pop (return)
//   ret_pc              out  PC_WIDTH  current top entry stack[index]; combinational from state
//   ret_underflow       out  1         ret_valid && count==0 (ret_pc is stale)
//   ras_index           out  IDX_W     current top index, pre-update (checkpoint for this access)
//   ras_count           out  CNT_W     current occupancy, pre-update (checkpoint for this access)
//   update_valid        in   1         restore checkpoint (mispredict/flush)
//   update_ras_index    in   IDX_W     index to restore
//   update_ras_count    in   CNT_W     count to restore
// BEHAVIOUR
//   State
//   - stack[RAS_ENTRIES] of PC_WIDTH.
//   - index (IDX_W): points at the top valid entry.
//   - count (CNT_W): saturates in [0, RAS_ENTRIES].
//   Reset (async, nRST=0)
//   - stack[*]=INIT_PC, index=0, count=0.
//   - Outputs: ret_pc=INIT_PC, ret_underflow=0, ras_index=0, ras_count=0.
//   - Reset mid-operation discards all contents immediately; no partial write survives.
//   Outputs
//   - All outputs reflect current registered state, zero-latency combinational.
//   - A push/pop takes effect the next cycle (1-cycle update latency).
//   Per-cycle priority, mutually exclusive cases
//   1. update_valid: index <= update_ras_index; count <= min(update_ras_count, RAS_ENTRIES).
//      - Stack contents are untouched.
//      - link_valid and ret_valid are ignored this cycle.
//   2. link_valid && ret_valid (replace top):
//      - stack[index] <= link_pc; index unchanged.
//      - count <= (count==0) ? 1 : count.
//   3. link_valid only (push):
//      - index <= index+1 mod RAS_ENTRIES; stack[index+1] <= link_pc.
//      - count <= min(count+1, RAS_ENTRIES).
//   4. ret_valid only (pop):
//      - index <= index-1 mod RAS_ENTRIES; count <= (count==0) ? 0 : count-1.
//      - The index still decrements on underflow, keeping the pointer consistent with the backend checkpoint.
//   5. none: hold.
//   Boundaries
//   - Full push overwrites the oldest entry (wrap); count stays RAS_ENTRIES.
//   - Pop at count==0 asserts ret_underflow in the same cycle and returns stale stack[index].
//   - An update with count > RAS_ENTRIES is clamped.
//   - Index arithmetic is modulo 2^IDX_W; no wrap detection beyond count.
// TESTING
//   T1 reset
//      nRST=0 mid-traffic -> ret_pc=0, ras_index=0, ras_count=0, ret_underflow=0 same cycle.
//   T2 push/pop order
//      push 0x100, 0x200, 0x300 -> ras_count=3, ras_index=3, ret_pc=0x300.
//      3 pops -> ret_pc 0x300, 0x200, 0x100; count 0.
//   T3 overflow wrap (RAS_ENTRIES=16)
//      17 pushes of 0x1..0x11 -> count=16, index=1, ret_pc=0x11.
//      16 pops return 0x11..0x2; 17th pop -> ret_underflow=1.
//   T4 replace
//      stack top 0x40, count=2; link_valid+ret_valid with link_pc=0x80 -> next ret_pc=0x80, count=2, index unchanged.
//      Same at count=0 -> count=1.
//   T5 restore priority
//      Checkpoint idx=5, cnt=5. Push 3, pop 1.
//      Then update_valid(5,5) with link_valid=1 in the same cycle -> index=5, count=5, no write.
//      ret_pc = the value at idx 5 before the pushes.
//   T6 clamp
//      update_ras_count=31 -> count=16.
// ---------------------------------------------------------------------------------------------

Source files
------------

// File: rtl/ras_restorable.sv
`default_nettype none
// ============================================================================
// Module   : ras_restorable
// Purpose  : Return address stack for the fetch predictor. It is a circular
//            buffer with a wrapping top index and a saturating occupancy count.
//            Every access exposes an {index, count} checkpoint. A backend
//            update restores that checkpoint in a single cycle. The stack also
//            supports a simultaneous pop+push (replace top) and reports
//            underflow.
// Ports    :
//   CLK              in   clock; all state updates on the rising edge
//   nRST             in   asynchronous active-low reset
//   link_valid       in   push link_pc (call)
//   link_pc          in   return PC to push
//   ret_valid        in   pop (return)
//   ret_pc           out  current top entry stack[index]
//   ret_underflow    out  ret_valid while the stack is empty
//   ras_index        out  current top index (checkpoint, pre-update)
//   ras_count        out  current occupancy (checkpoint, pre-update)
//   update_valid     in   restore a checkpoint (mispredict / flush)
//   update_ras_index in   index to restore
//   update_ras_count in   count to restore (clamped to RAS_ENTRIES)
// Revision : 1.0 - initial release
// ============================================================================
module ras_restorable #(
   parameter int                    RAS_ENTRIES = 16,
   parameter int                    PC_WIDTH    = 38,
   parameter logic [PC_WIDTH-1:0]   INIT_PC     = '0,
   localparam int                   IDX_W       = $clog2(RAS_ENTRIES),
   localparam int                   CNT_W       = IDX_W + 1
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  link_valid,
   input  logic [PC_WIDTH-1:0]   link_pc,
   input  logic                  ret_valid,
   output logic [PC_WIDTH-1:0]   ret_pc,
   output logic                  ret_underflow,
   output logic [IDX_W-1:0]      ras_index,
   output logic [CNT_W-1:0]      ras_count,
   input  logic                  update_valid,
   input  logic [IDX_W-1:0]      update_ras_index,
   input  logic [CNT_W-1:0]      update_ras_count
);

   localparam logic [CNT_W-1:0] c_max_count = CNT_W'(RAS_ENTRIES);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
   localparam logic [IDX_W-1:0] c_idx_one   = IDX_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [PC_WIDTH-1:0] r_stack [RAS_ENTRIES];
   logic [IDX_W-1:0]    r_index;
   logic [CNT_W-1:0]    r_count;

   // ------------------------------------------------------------------------
   // Next-state signals
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0]    w_idx_inc;
   logic [IDX_W-1:0]    w_idx_dec;
   logic [IDX_W-1:0]    w_next_index;
   logic [CNT_W-1:0]    w_next_count;
   logic                w_wr_en;
   logic [IDX_W-1:0]    w_wr_idx;
   logic [CNT_W-1:0]    w_upd_count_clamped;

   // Index arithmetic wraps naturally at 2^IDX_W; RAS_ENTRIES is a power of 2.
   assign w_idx_inc = r_index + c_idx_one;
   assign w_idx_dec = r_index - c_idx_one;

   // The checkpoint count may come from a wider or corrupted source; never let
   // occupancy exceed the physical depth.
   assign w_upd_count_clamped = (update_ras_count > c_max_count) ? c_max_count
                                                                 : update_ras_count;

   always_comb begin
      w_next_index = r_index;
      w_next_count = r_count;
      w_wr_en      = 1'b0;
      w_wr_idx     = r_index;

      if (update_valid) begin
         // Restore wins over any speculative access in the same cycle; stack
         // contents are left exactly as they are.
         w_next_index = update_ras_index;
         w_next_count = w_upd_count_clamped;
      end else if (link_valid && ret_valid) begin
         // Coroutine-style return+call: overwrite the top in place.
         w_wr_en      = 1'b1;
         w_wr_idx     = r_index;
         w_next_count = (r_count == '0) ? c_cnt_one : r_count;
      end else if (link_valid) begin
         // Push; when full, the slot written is the oldest entry.
         w_wr_en      = 1'b1;
         w_wr_idx     = w_idx_inc;
         w_next_index = w_idx_inc;
         w_next_count = (r_count == c_max_count) ? c_max_count : (r_count + c_cnt_one);
      end else if (ret_valid) begin
         // Pop. The index moves even on underflow so that it stays in step
         // with the checkpoint the backend will later hand back.
         w_next_index = w_idx_dec;
         w_next_count = (r_count == '0) ? '0 : (r_count - c_cnt_one);
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_index <= '0;
         r_count <= '0;
      end else begin
         r_index <= w_next_index;
         r_count <= w_next_count;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < RAS_ENTRIES; i++) begin
            r_stack[i] <= INIT_PC;
         end
      end else if (w_wr_en) begin
         r_stack[w_wr_idx] <= link_pc;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: straight from registered state
   // ------------------------------------------------------------------------
   assign ret_pc        = r_stack[r_index];
   assign ret_underflow = ret_valid && (r_count == '0);
   assign ras_index     = r_index;
   assign ras_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ras_restorable.sv
`default_nettype none
// ============================================================================
// Module   : tb_ras_restorable
// Purpose  : Self-checking bench for ras_restorable (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ras_restorable;

   localparam int PCW = 38;

   logic            clk;
   logic            nrst;
   logic            link_valid;
   logic [PCW-1:0]  link_pc;
   logic            ret_valid;
   logic [PCW-1:0]  ret_pc;
   logic            ret_underflow;
   logic [3:0]      ras_index;
   logic [4:0]      ras_count;
   logic            update_valid;
   logic [3:0]      update_ras_index;
   logic [4:0]      update_ras_count;

   int n_cmp  = 0;
   int n_fail = 0;

   ras_restorable #(
      .RAS_ENTRIES (16),
      .PC_WIDTH    (PCW),
      .INIT_PC     ('0)
   ) dut (
      .CLK              (clk),
      .nRST             (nrst),
      .link_valid       (link_valid),
      .link_pc          (link_pc),
      .ret_valid        (ret_valid),
      .ret_pc           (ret_pc),
      .ret_underflow    (ret_underflow),
      .ras_index        (ras_index),
      .ras_count        (ras_count),
      .update_valid     (update_valid),
      .update_ras_index (update_ras_index),
      .update_ras_count (update_ras_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic           uv;
      logic [3:0]     ui;
      logic [4:0]     uc;
      logic           lv;
      logic [PCW-1:0] lp;
      logic           rv;
      logic [PCW-1:0] e_pc;
      logic [3:0]     e_idx;
      logic [4:0]     e_cnt;
      logic           e_uf;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic uv, input logic [3:0] ui, input logic [4:0] uc,
                        input logic lv, input logic [PCW-1:0] lp, input logic rv);
      update_valid     = uv;
      update_ras_index = ui;
      update_ras_count = uc;
      link_valid       = lv;
      link_pc          = lp;
      ret_valid        = rv;
   endtask

   task automatic idle();
      drive(1'b0, 4'd0, 5'd0, 1'b0, '0, 1'b0);
   endtask

   // Inputs were driven just after a rising edge; sample at the falling edge,
   // then let the state update on the next rising edge.
   task automatic chk_state(input string nm, input logic [PCW-1:0] e_pc,
                            input logic [3:0] e_idx, input logic [4:0] e_cnt, input logic e_uf);
      @(negedge clk);
      chk({nm, ".ret_pc"},    64'(ret_pc),        64'(e_pc));
      chk({nm, ".index"},     64'(ras_index),     64'(e_idx));
      chk({nm, ".count"},     64'(ras_count),     64'(e_cnt));
      chk({nm, ".underflow"}, 64'(ret_underflow), 64'(e_uf));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            uv    ui     uc     lv    lp         rv      e_pc       e_idx  e_cnt  e_uf
      vecs[0]  = '{1'b0, 4'd0, 5'd0,  1'b1, 38'h100,  1'b0,   38'h0,     4'd0,  5'd0,  1'b0};
      vecs[1]  = '{1'b0, 4'd0, 5'd0,  1'b1, 38'h200,  1'b0,   38'h100,   4'd1,  5'd1,  1'b0};
      vecs[2]  = '{1'b0, 4'd0, 5'd0,  1'b1, 38'h300,  1'b0,   38'h200,   4'd2,  5'd2,  1'b0};
      vecs[3]  = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b1,   38'h300,   4'd3,  5'd3,  1'b0};
      vecs[4]  = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b1,   38'h200,   4'd2,  5'd2,  1'b0};
      vecs[5]  = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b1,   38'h100,   4'd1,  5'd1,  1'b0};
      vecs[6]  = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b1,   38'h0,     4'd0,  5'd0,  1'b1};
      vecs[7]  = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b0,   38'h0,     4'd15, 5'd0,  1'b0};
      vecs[8]  = '{1'b0, 4'd0, 5'd0,  1'b1, 38'h80,   1'b1,   38'h0,     4'd15, 5'd0,  1'b1};
      vecs[9]  = '{1'b0, 4'd0, 5'd0,  1'b1, 38'h40,   1'b0,   38'h80,    4'd15, 5'd1,  1'b0};
      vecs[10] = '{1'b0, 4'd0, 5'd0,  1'b1, 38'h99,   1'b1,   38'h40,    4'd0,  5'd2,  1'b0};
      vecs[11] = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b0,   38'h99,    4'd0,  5'd2,  1'b0};
      vecs[12] = '{1'b1, 4'd3, 5'd31, 1'b0, 38'h0,    1'b0,   38'h99,    4'd0,  5'd2,  1'b0};
      vecs[13] = '{1'b1, 4'd1, 5'd2,  1'b1, 38'hBAD,  1'b1,   38'h300,   4'd3,  5'd16, 1'b0};
      vecs[14] = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b0,   38'h100,   4'd1,  5'd2,  1'b0};
      vecs[15] = '{1'b1, 4'd0, 5'd16, 1'b0, 38'h0,    1'b0,   38'h100,   4'd1,  5'd2,  1'b0};
      vecs[16] = '{1'b0, 4'd0, 5'd0,  1'b0, 38'h0,    1'b0,   38'h99,    4'd0,  5'd16, 1'b0};

      nrst = 1'b0;
      idle();
      do_reset();

      // Reset state
      chk_state("reset", '0, 4'd0, 5'd0, 1'b0);
      step();

      // Push/pop order, underflow, replace, restore priority and clamping
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].uv, vecs[i].ui, vecs[i].uc, vecs[i].lv, vecs[i].lp, vecs[i].rv);
         chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_idx, vecs[i].e_cnt, vecs[i].e_uf);
         step();
      end
      idle();

      // Overflow wrap: 17 pushes into 16 entries
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         drive(1'b0, 4'd0, 5'd0, 1'b1, PCW'(k), 1'b0);
         step();
      end
      idle();
      chk_state("wrap_full", 38'h11, 4'd1, 5'd16, 1'b0);
      step();
      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 4'd0, 5'd0, 1'b0, '0, 1'b1);
         @(negedge clk);
         chk($sformatf("wrap_pop%0d.ret_pc", k), 64'(ret_pc), 64'(17 - k));
         chk($sformatf("wrap_pop%0d.underflow", k), 64'(ret_underflow), 64'd0);
         step();
      end
      drive(1'b0, 4'd0, 5'd0, 1'b0, '0, 1'b1);
      chk_state("wrap_pop16", 38'h11, 4'd1, 5'd0, 1'b1);
      step();
      idle();

      // Asynchronous reset in the middle of a push
      drive(1'b0, 4'd0, 5'd0, 1'b1, 38'h55, 1'b0);
      #2;
      nrst = 1'b0;
      #1;
      chk("async_rst.ret_pc", 64'(ret_pc), 64'd0);
      chk("async_rst.index", 64'(ras_index), 64'd0);
      chk("async_rst.count", 64'(ras_count), 64'd0);
      chk("async_rst.underflow", 64'(ret_underflow), 64'd0);
      idle();
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      step();
      // Entry 0 held 0x10 before reset; it must be cleared.
      chk_state("post_rst", '0, 4'd0, 5'd0, 1'b0);
      step();

      // Restore priority over a simultaneous push
      for (int k = 1; k <= 5; k++) begin
         drive(1'b0, 4'd0, 5'd0, 1'b1, PCW'(32'hA0 + k), 1'b0);
         step();
      end
      idle();
      chk_state("ckpt", 38'hA5, 4'd5, 5'd5, 1'b0);
      step();
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, 4'd0, 5'd0, 1'b1, PCW'(32'hB0 + k), 1'b0);
         step();
      end
      drive(1'b0, 4'd0, 5'd0, 1'b0, '0, 1'b1);
      step();
      drive(1'b1, 4'd5, 5'd5, 1'b1, 38'hDEAD, 1'b0);
      chk_state("pre_restore", 38'hB2, 4'd7, 5'd7, 1'b0);
      step();
      idle();
      chk_state("restored", 38'hA5, 4'd5, 5'd5, 1'b0);
      step();
      // Neither entry 8 (push target) nor entry 7 may hold the ignored link_pc.
      drive(1'b1, 4'd8, 5'd8, 1'b0, '0, 1'b0);
      step();
      idle();
      chk_state("no_write8", 38'hB3, 4'd8, 5'd8, 1'b0);
      step();
      drive(1'b1, 4'd7, 5'd7, 1'b0, '0, 1'b0);
      step();
      idle();
      chk_state("no_write7", 38'hB2, 4'd7, 5'd7, 1'b0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
